core_inst_seq: RTL and testbench

Instruction sequencer that drives the 34-bit `inst` bus of `core` for one complete layer tile. After a single `start` pulse it performs four phases in order: weight fetch into L0, kernel load, activation fetch plus execute, and psum drain into psum SRAM. It watches `L0_full` and `ofifo_valid` from `core` and handles SRAM read latency with a one-entry skid buffer. It replaces testbench-driven instruction streams.

---
 rtl/core_inst_seq.sv | 204 ++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq: sequences one layer tile on the core inst bus.
// Phases: weight fetch into L0, kernel load, activation fetch + execute, psum drain.
// Ports: clk/reset; start, w_base/a_base/p_base/len/acc_en (sampled on start);
//        L0_full/ofifo_valid from core; inst (34b) to core; busy, done status.
module core_inst_seq #(
  parameter int col = 8,
  parameter int row = 8,
  parameter int aw  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] w_base,
  input  logic [aw-1:0] a_base,
  input  logic [aw-1:0] p_base,
  input  logic [aw-1:0] len,
  input  logic          acc_en,
  input  logic          L0_full,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
);

  localparam int            CW     = $clog2(col + row + 1);
  localparam logic [aw-1:0] COL_N  = aw'(col);
  localparam logic [33:0]   IDLE_W = 34'h1_800C_0000;  // both SRAMs CEN=1, WEN=1

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_KLOAD, S_KWAIT, S_AFETCH, S_DRAIN, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [aw-1:0] w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
  logic [aw-1:0] len_q, len_d;
  logic          acc_q, acc_d;
  logic [aw-1:0] issued_q, issued_d;      // xmem reads issued in current fetch phase
  logic [aw-1:0] wcnt_q, wcnt_d;          // l0 writes in current fetch phase
  logic          rd_pend_q, rd_pend_d;    // xmem read last cycle -> Q valid now
  logic          skid_q, skid_d;          // word parked in SRAM output register
  logic          full_q;                  // L0_full from previous cycle
  logic          ofv_q;                   // ofifo_valid from previous cycle
  logic          exec_pend_q, exec_pend_d;
  logic [aw-1:0] exec_cnt_q, exec_cnt_d;
  logic [aw-1:0] ofrd_cnt_q, ofrd_cnt_d;
  logic          pw_pend_q, pw_pend_d;    // ofifo_rd last cycle -> pmem write now
  logic [aw-1:0] pw_cnt_q, pw_cnt_d;

  logic          fetch_act, drain_act, q_avail, l0_wr, xrd, ofrd;
  logic [aw-1:0] fetch_n, fetch_base;

  // Flow-control inputs act through their registered copies only, so inst
  // never has a combinational path from L0_full or ofifo_valid.
  assign fetch_act  = (state_q == S_WFETCH) || (state_q == S_AFETCH);
  assign drain_act  = (state_q == S_AFETCH) || (state_q == S_DRAIN);
  assign fetch_n    = (state_q == S_WFETCH) ? COL_N : len_q;
  assign fetch_base = (state_q == S_WFETCH) ? w_base_q : a_base_q;
  assign q_avail    = rd_pend_q | skid_q;
  assign l0_wr      = fetch_act & q_avail & ~full_q;
  // A new read needs an empty skid so the parked word is never overwritten.
  assign xrd        = fetch_act & ~full_q & ~skid_q & (issued_q < fetch_n);
  assign ofrd       = drain_act & ofv_q & (ofrd_cnt_q < len_q);

  assign busy = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done = (state_q == S_FIN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_base_d    = w_base_q;
    a_base_d    = a_base_q;
    p_base_d    = p_base_q;
    len_d       = len_q;
    acc_d       = acc_q;
    issued_d    = issued_q + aw'(xrd);
    wcnt_d      = wcnt_q + aw'(l0_wr);
    rd_pend_d   = xrd;
    // Q not taken this cycle stays in the SRAM output register.
    skid_d      = fetch_act & q_avail & full_q;
    exec_pend_d = l0_wr & (state_q == S_AFETCH);
    exec_cnt_d  = exec_cnt_q + aw'(exec_pend_q);
    ofrd_cnt_d  = ofrd_cnt_q + aw'(ofrd);
    pw_pend_d   = ofrd;
    pw_cnt_d    = pw_cnt_q + aw'(pw_pend_q);

    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        issued_d   = '0;
        wcnt_d     = '0;
        exec_cnt_d = '0;
        ofrd_cnt_d = '0;
        pw_cnt_d   = '0;
        if (start) begin
          w_base_d = w_base;
          a_base_d = a_base;
          p_base_d = p_base;
          len_d    = len;
          acc_d    = acc_en;
          // len=0 spends one empty cycle in DRAIN, so done lands two cycles after start.
          state_d  = (len == '0) ? S_DRAIN : S_WFETCH;
        end
      end
      S_WFETCH: begin
        if (wcnt_d == COL_N) begin
          state_d  = S_KLOAD;
          cnt_d    = '0;
          issued_d = '0;
          wcnt_d   = '0;
        end
      end
      S_KLOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(col - 1)) begin
          state_d = S_KWAIT;
          cnt_d   = '0;
        end
      end
      S_KWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(col + row - 1)) begin
          state_d = S_AFETCH;
          cnt_d   = '0;
        end
      end
      S_AFETCH: begin
        if (exec_cnt_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pw_cnt_d == len_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst = IDLE_W;
    if (xrd) begin
      inst[19]      = 1'b0;
      inst[7 +: aw] = fetch_base + issued_q;
    end
    inst[2] = l0_wr;
    if (state_q == S_KLOAD) begin
      inst[3] = 1'b1;
      inst[0] = 1'b1;
    end
    if (exec_pend_q) begin
      inst[3] = 1'b1;
      inst[1] = 1'b1;
    end
    inst[6] = ofrd;
    if (pw_pend_q) begin
      inst[33]       = acc_q;
      inst[32]       = 1'b0;
      inst[31]       = 1'b0;
      inst[20 +: aw] = p_base_q + pw_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      w_base_q    <= '0;
      a_base_q    <= '0;
      p_base_q    <= '0;
      len_q       <= '0;
      acc_q       <= 1'b0;
      issued_q    <= '0;
      wcnt_q      <= '0;
      rd_pend_q   <= 1'b0;
      skid_q      <= 1'b0;
      full_q      <= 1'b0;
      ofv_q       <= 1'b0;
      exec_pend_q <= 1'b0;
      exec_cnt_q  <= '0;
      ofrd_cnt_q  <= '0;
      pw_pend_q   <= 1'b0;
      pw_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_base_q    <= w_base_d;
      a_base_q    <= a_base_d;
      p_base_q    <= p_base_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      issued_q    <= issued_d;
      wcnt_q      <= wcnt_d;
      rd_pend_q   <= rd_pend_d;
      skid_q      <= skid_d;
      full_q      <= L0_full;
      ofv_q       <= ofifo_valid;
      exec_pend_q <= exec_pend_d;
      exec_cnt_q  <= exec_cnt_d;
      ofrd_cnt_q  <= ofrd_cnt_d;
      pw_pend_q   <= pw_pend_d;
      pw_cnt_q    <= pw_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
module tb_core_inst_seq;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int AW  = 11;
  localparam int BUDGET = 3000;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] w_base = '0, a_base = '0, p_base = '0, len = '0;
  logic          acc_en = 1'b0;
  logic          L0_full = 1'b0;
  logic          ofifo_valid = 1'b0;
  logic [33:0]   inst;
  logic          busy, done;

  core_inst_seq #(.col(COL), .row(ROW), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
    .p_base(p_base), .len(len), .acc_en(acc_en), .L0_full(L0_full),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Scoreboard: expected xmem read addresses and pmem write addresses, in order.
  logic [AW-1:0] exp_xa[$];
  logic [AW-1:0] exp_pa[$];
  logic          exp_acc;
  int            len_cur;

  // Environment: L0 stall pattern and OFIFO valid pattern.
  int stall_mode = 0;   // 0 none, 1 one 3-cycle hold in act phase, 2 random
  bit ofv_rand = 1'b0;
  int hold_left = 3;
  bit a_rd_seen;

  always @(posedge clk) begin
    #1;
    if (stall_mode != 1) hold_left = 3;
    case (stall_mode)
      1: begin
        if (a_rd_seen && hold_left > 0) begin
          L0_full = 1'b1;
          hold_left--;
        end else begin
          L0_full = 1'b0;
        end
      end
      2:       L0_full = ($urandom_range(0, 3) == 0);
      default: L0_full = 1'b0;
    endcase
    ofifo_valid = ofv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: decodes inst each cycle on the falling edge.
  int n_xrd, n_l0wr, n_exec, n_load, n_ofrd, n_pw, max_stale;
  int out_cnt, cyc = 0, last_load_cyc, first_a_cyc, stale;
  bit rd_prev, l0wr_prev, ofrd_prev;
  logic xrd, l0wr, ex, ld, ofrd, pw;

  always @(negedge clk) begin
    if (reset) begin
      out_cnt = 0; rd_prev = 0; l0wr_prev = 0; ofrd_prev = 0; a_rd_seen = 0;
    end else begin
      cyc++;
      if (start && !busy) begin
        n_xrd = 0; n_l0wr = 0; n_exec = 0; n_load = 0; n_ofrd = 0; n_pw = 0;
        max_stale = 0; out_cnt = 0; a_rd_seen = 0; last_load_cyc = 0; first_a_cyc = 0;
      end
      xrd  = ~inst[19];
      l0wr = inst[2];
      ex   = inst[1];
      ld   = inst[0];
      ofrd = inst[6];
      pw   = ~inst[32];
      // words read two or more cycles ago and still unwritten sit in the skid
      stale = out_cnt - (rd_prev ? 1 : 0);
      if (stale > max_stale) max_stale = stale;
      if (l0wr) begin
        n_l0wr++;
        chk("l0_wr_has_word", out_cnt > 0, 1);
        if (out_cnt > 0) out_cnt--;
      end
      if (xrd) begin
        n_xrd++;
        chk("xrd_while_skid", stale, 0);
        chk("xmem_wen", inst[18], 1);
        if (exp_xa.size() == 0) fail_now("xmem_unexpected_read");
        else chk("xmem_addr", inst[17:7], exp_xa.pop_front());
        out_cnt++;
        if (n_load == COL && !a_rd_seen) begin
          a_rd_seen = 1;
          first_a_cyc = cyc;
        end
      end
      if (ex) begin
        n_exec++;
        chk("exec_lag", l0wr_prev, 1);
        chk("exec_l0rd", inst[3], 1);
      end
      if (ld) begin
        n_load++;
        last_load_cyc = cyc;
        chk("load_l0rd", inst[3], 1);
      end
      if (ofrd) begin
        n_ofrd++;
        chk("ofrd_bound", n_ofrd <= len_cur, 1);
      end
      if (pw || ofrd_prev) chk("pw_follows_ofrd", pw, ofrd_prev);
      if (pw) begin
        n_pw++;
        chk("pmem_wen", inst[31], 0);
        chk("pmem_acc", inst[33], exp_acc);
        if (exp_pa.size() == 0) fail_now("pmem_unexpected_write");
        else chk("pmem_addr", inst[30:20], exp_pa.pop_front());
      end
      rd_prev = xrd; l0wr_prev = l0wr; ofrd_prev = ofrd;
    end
  end

  task automatic launch(input logic [AW-1:0] wb, ab, pb, ln, input logic acc);
    len_cur = int'(ln);
    exp_acc = acc;
    if (ln != 0) begin
      for (int i = 0; i < COL; i++) exp_xa.push_back(AW'((int'(wb) + i) % (1 << AW)));
      for (int i = 0; i < int'(ln); i++) exp_xa.push_back(AW'((int'(ab) + i) % (1 << AW)));
      for (int i = 0; i < int'(ln); i++) exp_pa.push_back(AW'((int'(pb) + i) % (1 << AW)));
    end
    @(posedge clk); #1;
    w_base = wb; a_base = ab; p_base = pb; len = ln; acc_en = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_seq(input logic [AW-1:0] wb, ab, pb, ln, input logic acc,
                         input int smode, input bit orand, input bit poke);
    int k;
    bit got;
    ofv_rand = orand;
    launch(wb, ab, pb, ln, acc);
    stall_mode = smode;
    k = 0;
    got = 0;
    while (k < BUDGET && !got) begin
      @(negedge clk);
      k++;
      if (poke && k == 5) begin start = 1'b1; len = 7; w_base = 5; end
      if (poke && k == 6) start = 1'b0;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    if (ln == 0) chk("done_latency_len0", k, 2);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("load_count", n_load, (ln == 0) ? 0 : COL);
    chk("xrd_count", n_xrd, (ln == 0) ? 0 : COL + int'(ln));
    chk("l0wr_count", n_l0wr, (ln == 0) ? 0 : COL + int'(ln));
    chk("exec_count", n_exec, int'(ln));
    chk("ofrd_count", n_ofrd, int'(ln));
    chk("pw_count", n_pw, int'(ln));
    chk("xa_left", exp_xa.size(), 0);
    chk("pa_left", exp_pa.size(), 0);
    if (ln != 0 && smode == 0) begin
      chk("kwait_gap", first_a_cyc - last_load_cyc - 1, COL + ROW);
      chk("no_stall_skid", max_stale, 0);
    end
    if (smode == 1) chk("one_word_parked", max_stale, 1);
    stall_mode = 0;
    ofv_rand = 0;
  endtask

  initial begin
    int k;
    #1;
    chk("rst_inst", inst, IDLE_W);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_seq(11'd0, 11'd16, 11'd100, 11'd4, 1'b1, 0, 0, 1);
    run_seq(11'd3, 11'd40, 11'd7, 11'd0, 1'b1, 0, 0, 0);
    run_seq(11'd20, 11'd60, 11'd300, 11'd6, 1'b0, 1, 0, 0);
    run_seq(11'd2040, 11'd2045, 11'd2046, 11'd4, 1'b0, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      run_seq(AW'($urandom_range(0, 2047)), AW'($urandom_range(0, 2047)),
              AW'($urandom_range(0, 2047)), AW'($urandom_range(1, 20)),
              1'($urandom_range(0, 1)), 2, 1, 0);

    // Reset in the middle of the activation phase.
    launch(11'd0, 11'd16, 11'd100, 11'd8, 1'b1);
    k = 0;
    while (k < BUDGET && !a_rd_seen) begin @(negedge clk); k++; end
    chk("afetch_reached", a_rd_seen, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_inst", inst, IDLE_W);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_xa.delete();
    exp_pa.delete();
    @(negedge clk);
    chk("midrst_hold", inst, IDLE_W);
    @(posedge clk); #1;
    reset = 1'b0;
    run_seq(11'd0, 11'd16, 11'd100, 11'd4, 1'b1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
